// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-back path.
package regfile_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned N_WB_SRC = 3;

    // Requester slots on the write-back arbiter
    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_LSU = 1;
    localparam int unsigned SRC_CSR = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after ptr, first request wins.
module rr_arbiter #(
    parameter  int unsigned N  = 3,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && req[j] && (((32'(ptr) + k) % N) == j)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter, output stage and pending-write scoreboard for the 32x32 register file.
// Optional feature macro BYPASS_EN: forward the committing write to rs1/rs2 and mask busy.
module regfile_wb_arbiter #(
    parameter int unsigned N_SRC = regfile_pkg::N_WB_SRC,
    parameter int unsigned XLEN  = regfile_pkg::XLEN,
    parameter int unsigned AW    = regfile_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      wb_valid,
    input  logic [N_SRC*AW-1:0]   wb_rd,
    input  logic [N_SRC*XLEN-1:0] wb_data,
    output logic [N_SRC-1:0]      wb_ready,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic [AW-1:0]         rs1,
    input  logic [AW-1:0]         rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  fwd1,
    output logic                  fwd2,
    output logic [XLEN-1:0]       fwd_data
);

    localparam int unsigned PW    = $clog2(N_SRC);
    localparam int unsigned NREGS = 32'(1) << AW;

    logic [PW-1:0]    r_ptr;
    logic             r_we;
    logic [AW-1:0]    r_waddr;
    logic [XLEN-1:0]  r_wdata;
    logic [NREGS-1:0] r_pending;

    logic [N_SRC-1:0] w_gnt;
    logic             w_hs;
    logic [PW-1:0]    w_gnt_idx;
    logic [AW-1:0]    w_sel_rd;
    logic [XLEN-1:0]  w_sel_data;
    logic [NREGS-1:0] w_pending_nxt;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req (wb_valid),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    // Output stage never stalls, so a grant is always a completed handshake
    assign wb_ready = rst ? '0 : w_gnt;
    assign w_hs     = |wb_ready;

    always_comb begin
        w_gnt_idx  = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = PW'(i);
                w_sel_rd   = wb_rd[i*AW +: AW];
                w_sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // Issue set takes precedence over a same-cycle commit clear
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_we) begin
            w_pending_nxt[r_waddr] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= PW'(N_SRC - 1);
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_we      <= w_hs && (w_sel_rd != '0);
            if (w_hs) begin
                r_ptr   <= w_gnt_idx;
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

`ifdef BYPASS_EN
    assign fwd1     = r_we && (r_waddr == rs1) && (rs1 != '0);
    assign fwd2     = r_we && (r_waddr == rs2) && (rs2 != '0);
    assign fwd_data = r_wdata;
`else
    assign fwd1     = 1'b0;
    assign fwd2     = 1'b0;
    assign fwd_data = '0;
`endif

    // A register being written this cycle is not a stall once it can be forwarded
    assign busy1 = r_pending[rs1] & ~fwd1;
    assign busy2 = r_pending[rs2] & ~fwd2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes queued at handshake, popped at commit.
module tb_regfile_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned XL = 32;
    localparam int unsigned A  = 5;

    typedef struct packed {
        logic [A-1:0]  addr;
        logic [XL-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    wb_valid;
    logic [N*A-1:0]  wb_rd;
    logic [N*XL-1:0] wb_data;
    logic [N-1:0]    wb_ready;
    logic            issue_valid;
    logic [A-1:0]    issue_rd;
    logic [A-1:0]    rs1;
    logic [A-1:0]    rs2;
    logic            busy1;
    logic            busy2;
    logic            rf_we;
    logic [A-1:0]    rf_waddr;
    logic [XL-1:0]   rf_wdata;
    logic            fwd1;
    logic            fwd2;
    logic [XL-1:0]   fwd_data;

    regfile_wb_arbiter #(.N_SRC(N), .XLEN(XL), .AW(A)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy1       (busy1),
        .busy2       (busy2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd1        (fwd1),
        .fwd2        (fwd2),
        .fwd_data    (fwd_data)
    );

    always #5 clk = ~clk;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    wr_t           exp_q[$];
    int unsigned   m_ptr;
    logic          m_we;
    logic [A-1:0]  m_waddr;
    logic [XL-1:0] m_wdata;
    logic [31:0]   m_pend;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_src(input int unsigned i, input logic [A-1:0] rd, input logic [XL-1:0] d);
        wb_rd[i*A +: A]    = rd;
        wb_data[i*XL +: XL] = d;
    endtask

    // Commit monitor: every register-file write must match the oldest queued expectation
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 64'(rf_waddr), 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr", 64'(rf_waddr), 64'(e.addr));
                check_eq("wr_data", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    // Check combinational/registered outputs against the model, then advance one clock
    task automatic tick();
        logic [N-1:0] eg;
        int unsigned  gi;
        int unsigned  idx;
        logic [31:0]  np;
        logic         ef1;
        logic         ef2;
        #1;
        eg = '0;
        gi = 0;
        if (!rst) begin
            for (int unsigned k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (eg == '0 && wb_valid[idx]) begin
                    eg[idx] = 1'b1;
                    gi      = idx;
                end
            end
        end
        ef1 = 1'b0;
        ef2 = 1'b0;
`ifdef BYPASS_EN
        ef1 = m_we && (m_waddr == rs1) && (rs1 != '0);
        ef2 = m_we && (m_waddr == rs2) && (rs2 != '0);
        if (ef1 || ef2) check_eq("fwd_data", 64'(fwd_data), 64'(m_wdata));
`else
        check_eq("fwd_data", 64'(fwd_data), 64'd0);
`endif
        check_eq("gnt", 64'(wb_ready), 64'(eg));
        check_eq("rf_we", 64'(rf_we), 64'(m_we));
        check_eq("busy1", 64'(busy1), 64'(m_pend[rs1] & ~ef1));
        check_eq("busy2", 64'(busy2), 64'(m_pend[rs2] & ~ef2));
        check_eq("fwd1", 64'(fwd1), 64'(ef1));
        check_eq("fwd2", 64'(fwd2), 64'(ef2));

        np = m_pend;
        if (m_we) np[m_waddr] = 1'b0;
        if (issue_valid && issue_rd != '0) np[issue_rd] = 1'b1;
        np[0] = 1'b0;
        if (rst) begin
            m_ptr   = N - 1;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_pend  = '0;
        end else begin
            m_pend = np;
            m_we   = 1'b0;
            if (eg != '0) begin
                m_ptr   = gi;
                m_waddr = wb_rd[gi*A +: A];
                m_wdata = wb_data[gi*XL +: XL];
                m_we    = (m_waddr != '0);
                if (m_we) exp_q.push_back('{addr: m_waddr, data: m_wdata});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_valid = '0; wb_rd = '0; wb_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        m_ptr = N - 1; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_pend = '0;
        @(posedge clk);
        #1;
        wb_valid = 3'b111;
        tick();
        tick();

        // Reset state
        rst = 1'b0; wb_valid = '0; rs1 = 5'd5; rs2 = 5'd9;
        #1;
        check_eq("rst_we", 64'(rf_we), 64'd0);
        check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
        check_eq("rst_wdata", 64'(rf_wdata), 64'd0);
        check_eq("rst_busy1", 64'(busy1), 64'd0);

        // All sources valid: rotation 001,010,100,001
        wb_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            for (int unsigned i = 0; i < N; i++) set_src(i, A'(10 + i), $urandom);
            tick();
        end
        wb_valid = '0;
        tick();
        tick();

        // Issue rd5 then ALU write-back to rd5 with rs1=5 throughout
        rs1 = 5'd5; rs2 = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        set_src(0, 5'd5, 32'hDEADBEEF);
        wb_valid = 3'b001;
        tick();
        wb_valid = '0;
        tick();
        tick();
        tick();

        // x0 write-back: handshake completes, nothing committed
        rs1 = 5'd0;
        set_src(1, 5'd0, 32'h1234);
        wb_valid = 3'b010;
        tick();
        wb_valid = '0;
        tick();
        tick();

        // Issue rd7 in the same cycle rd7 commits: pending stays set
        rs1 = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        set_src(2, 5'd7, $urandom);
        wb_valid = 3'b100;
        tick();
        wb_valid = '0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        tick();
        tick();

        // Mid-operation reset with pending entries and requests in flight
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        set_src(1, 5'd12, $urandom);
        wb_valid = 3'b010;
        tick();
        wb_valid = '0;
        rs1 = 5'd3; rs2 = 5'd9;
        tick();
        rst = 1'b1;
        wb_valid = 3'b110;
        set_src(1, 5'd13, $urandom);
        set_src(2, 5'd14, $urandom);
        tick();
        rst = 1'b0;
        check_eq("post_rst_we", 64'(rf_we), 64'd0);
        tick();
        tick();
        wb_valid = '0;
        tick();
        tick();

        // Single source streaming back to back
        rs1 = 5'd20; rs2 = 5'd21;
        wb_valid = 3'b100;
        for (int c = 0; c < 4; c++) begin
            set_src(2, A'(20 + c), $urandom);
            tick();
        end
        wb_valid = '0;
        tick();
        tick();
        tick();

        check_eq("q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
